// File: rtl/vga_pattern_gen_param.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen_param
//   Parametrised VGA timing and test-pattern generator. It owns the h/v
//   counters, generates sync and data-enable, and renders the selected test
//   pattern. The pattern select is latched only at the frame boundary, so a
//   frame is never rendered with two different patterns.
//
//   Optional feature macro: VGA_PATTERN_GEN_ANIM_EN
//     When it is defined, pattern 6 draws a 16-pixel white bar that moves one
//     pixel to the right per frame. When it is undefined, pattern 6 is black.
//
// Ports
//   i_CLK          pixel clock (single clock domain)
//   i_RESET        synchronous, active-high reset
//   i_PATTERN[3:0] pattern select, sampled at the frame boundary
//   i_RGB[7:0]     solid colour for pattern 1, RRRGGGBB
//   o_HSYNC        horizontal sync, active level SYNC_POL
//   o_VSYNC        vertical sync, active level SYNC_POL
//   o_DE           output pixel lies in the active area
//   o_FRAME_START  one-cycle pulse aligned with output pixel (0,0)
//   o_RED/GREEN/BLUE [COLOR_W-1:0] colour channels, 0 outside the active area
//
// All outputs are registered one clock behind the counters.
// -----------------------------------------------------------------------------
module vga_pattern_gen_param #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit SYNC_POL   = 1'b0,
   parameter int COLOR_W    = 4,
   parameter int GRAD_SHIFT = 5
) (
   input  logic               i_CLK,
   input  logic               i_RESET,
   input  logic [3:0]         i_PATTERN,
   input  logic [7:0]         i_RGB,
   output logic               o_HSYNC,
   output logic               o_VSYNC,
   output logic               o_DE,
   output logic               o_FRAME_START,
   output logic [COLOR_W-1:0] o_RED,
   output logic [COLOR_W-1:0] o_GREEN,
   output logic [COLOR_W-1:0] o_BLUE
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare value so that sync-end constants always fit even with a zero back porch.
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   // The pixel x is widened so the ramp slice and the checker bit always exist.
   localparam int XW_A    = (HW > GRAD_SHIFT + COLOR_W) ? HW : GRAD_SHIFT + COLOR_W;
   localparam int XW      = (XW_A > 6) ? XW_A : 6;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG       = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END       = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG       = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END       = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_BIT5       = VW'(32);

   logic [HW-1:0]      h_cnt_q, h_cnt_d;
   logic [VW-1:0]      v_cnt_q, v_cnt_d;
   logic [3:0]         pat_q, pat_d;
   logic               first_q;

   logic               hsync_q, vsync_q, de_q, fs_q;
   logic [COLOR_W-1:0] red_q, green_q, blue_q;

   logic               h_wrap, v_wrap, frame_end;
   logic [3:0]         pat_cur;
   logic [XW-1:0]      x_ext;
   logic               y_b5;
   logic               active, hs_act, vs_act, at_origin;
   logic [2:0]         bar;
   logic               white;
   logic [COLOR_W-1:0] red_px, green_px, blue_px;

`ifdef VGA_PATTERN_GEN_ANIM_EN
   logic [10:0]        pos_q, pos_d;
   logic [11:0]        x12, pos12;
   logic               in_bar;
`endif

   // Counters and pattern latch
   always_comb begin
      h_wrap    = (h_cnt_q == H_LAST);
      v_wrap    = (v_cnt_q == V_LAST);
      frame_end = h_wrap && v_wrap;

      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      end

      // The first cycle after reset renders pixel (0,0), so it must already
      // use the freshly sampled pattern rather than the reset value.
      pat_cur = first_q ? i_PATTERN : pat_q;
      pat_d   = pat_q;
      if (first_q || frame_end) begin
         pat_d = i_PATTERN;
      end
   end

`ifdef VGA_PATTERN_GEN_ANIM_EN
   always_comb begin
      pos_d = pos_q;
      if (frame_end && (pat_q == 4'd6)) begin
         pos_d = (pos_q == 11'(H_ACTIVE - 1)) ? '0 : pos_q + 11'd1;
      end
      x12    = 12'(h_cnt_q);
      pos12  = {1'b0, pos_q};
      in_bar = (x12 >= pos12) && (x12 < pos12 + 12'd16);
   end
`endif

   // Pixel rendering for the current counter position
   always_comb begin
      x_ext     = XW'(h_cnt_q);
      y_b5      = |(v_cnt_q & V_BIT5);
      active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_act    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs_act    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

      // Thresholds rise with k, so the last match is the bar index; the
      // remainder pixels past 8*BAR_W stay in bar 7.
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x_ext >= XW'(k * BAR_W)) bar = 3'(k);
      end

      white    = 1'b0;
      red_px   = '0;
      green_px = '0;
      blue_px  = '0;

      case (pat_cur)
         4'd1: begin
            // MSB replication: repeat the source field from the top down.
            for (int i = 0; i < COLOR_W; i++) begin
               red_px[COLOR_W-1-i]   = i_RGB[7 - (i % 3)];
               green_px[COLOR_W-1-i] = i_RGB[4 - (i % 3)];
               blue_px[COLOR_W-1-i]  = i_RGB[1 - (i % 2)];
            end
         end
         4'd2: begin
            red_px   = {COLOR_W{bar[2]}};
            green_px = {COLOR_W{bar[1]}};
            blue_px  = {COLOR_W{bar[0]}};
         end
         4'd3: white = ~(x_ext[5] ^ y_b5);
         4'd4: begin
            red_px   = x_ext[GRAD_SHIFT +: COLOR_W];
            green_px = x_ext[GRAD_SHIFT +: COLOR_W];
            blue_px  = x_ext[GRAD_SHIFT +: COLOR_W];
         end
         4'd5: white = (h_cnt_q == '0) || (h_cnt_q == H_ACT_LAST) ||
                       (v_cnt_q == '0) || (v_cnt_q == V_ACT_LAST);
`ifdef VGA_PATTERN_GEN_ANIM_EN
         4'd6: white = in_bar;
`endif
         default: white = 1'b0;
      endcase

      if (white) begin
         red_px   = '1;
         green_px = '1;
         blue_px  = '1;
      end
      if (!active) begin
         red_px   = '0;
         green_px = '0;
         blue_px  = '0;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         pat_q   <= '0;
         first_q <= 1'b1;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pat_q   <= pat_d;
         first_q <= 1'b0;
         hsync_q <= hs_act ? SYNC_POL : ~SYNC_POL;
         vsync_q <= vs_act ? SYNC_POL : ~SYNC_POL;
         de_q    <= active;
         fs_q    <= at_origin;
         red_q   <= red_px;
         green_q <= green_px;
         blue_q  <= blue_px;
      end
   end

`ifdef VGA_PATTERN_GEN_ANIM_EN
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end
`endif

   assign o_HSYNC       = hsync_q;
   assign o_VSYNC       = vsync_q;
   assign o_DE          = de_q;
   assign o_FRAME_START = fs_q;
   assign o_RED         = red_q;
   assign o_GREEN       = green_q;
   assign o_BLUE        = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen_param.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen_param
//   Bench for vga_pattern_gen_param with a reduced raster (118 x 47 clocks per
//   frame) so that several frames fit in a short run. A reference model works
//   from the cycle count since reset release: pixel index, x/y and the frame's
//   pattern all follow from plain arithmetic. Literal checks at chosen pixels
//   pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen_param;

   localparam int HA = 100, HF = 4, HS = 8, HB = 6;
   localparam int VA = 40,  VF = 2, VS = 2, VB = 3;
   localparam int CW = 4, GS = 2;
   localparam int HT = HA + HF + HS + HB;   // 118
   localparam int VT = VA + VF + VS + VB;   // 47
   localparam int FRAME = HT * VT;          // 5546
   localparam int LIM = 3 * FRAME;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    pat = 4'd1;
   logic [7:0]    rgb = 8'b101_110_01;
   logic          o_hs, o_vs, o_de, o_fs;
   logic [CW-1:0] o_r, o_g, o_b;

   int checks = 0;
   int errors = 0;

   vga_pattern_gen_param #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .COLOR_W(CW), .GRAD_SHIFT(GS)
   ) dut (
      .i_CLK(clk), .i_RESET(rst), .i_PATTERN(pat), .i_RGB(rgb),
      .o_HSYNC(o_hs), .o_VSYNC(o_vs), .o_DE(o_de), .o_FRAME_START(o_fs),
      .o_RED(o_r), .o_GREEN(o_g), .o_BLUE(o_b)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int expand(int v, int n);
      int r = 0;
      for (int i = 0; i < CW; i++)
         if (((v >> (n - 1 - (i % n))) & 1) != 0) r |= 1 << (CW - 1 - i);
      return r;
   endfunction

   function automatic logic [3*CW-1:0] model_rgb(int p, int c, int x, int y, int pos);
      int fs = (1 << CW) - 1;
      int r = 0, g = 0, b = 0, k;
      bit w = 0;
      if (x >= HA || y >= VA) return '0;
      case (p)
         1: begin
            r = expand((c >> 5) & 7, 3);
            g = expand((c >> 2) & 7, 3);
            b = expand(c & 3, 2);
         end
         2: begin
            k = x / (HA / 8);
            if (k > 7) k = 7;
            r = ((k >> 2) & 1) * fs;
            g = ((k >> 1) & 1) * fs;
            b = (k & 1) * fs;
         end
         3: w = (((x >> 5) ^ (y >> 5)) & 1) == 0;
         4: begin
            r = (x >> GS) % (1 << CW);
            g = r;
            b = r;
         end
         5: w = (x == 0) || (x == HA - 1) || (y == 0) || (y == VA - 1);
`ifdef VGA_PATTERN_GEN_ANIM_EN
         6: w = (x >= pos) && (x < pos + 16);
`endif
         default: w = 0;
      endcase
      if (w) begin
         r = fs; g = fs; b = fs;
      end
      return {CW'(r), CW'(g), CW'(b)};
   endfunction

   int            k_cyc = 0;
   int            cur_pat = 0, pend_pat = 0, mpos = 0;
   int            exp_x = 0, exp_y = 0;
   bit            exp_valid = 0, model_ok = 0;
   logic          exp_hs, exp_vs, exp_de, exp_fs;
   logic [3*CW-1:0] exp_rgb;

   always @(posedge clk) begin
      int n, x, y;
      if (rst) begin
         exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_fs = 1'b0; exp_rgb = '0;
         k_cyc = 0; cur_pat = 0; mpos = 0; exp_valid = 0; model_ok = 1;
      end else begin
         n = k_cyc % FRAME;
         x = n % HT;
         y = n / HT;
         if (k_cyc == 0) cur_pat = int'(pat);
         else if (n == 0) cur_pat = pend_pat;
         exp_de  = (x < HA) && (y < VA);
         exp_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
         exp_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
         exp_fs  = (n == 0);
         exp_rgb = model_rgb(cur_pat, int'(rgb), x, y, mpos);
         exp_x = x; exp_y = y; exp_valid = 1;
         if (n == FRAME - 1) begin
            if (cur_pat == 6) mpos = (mpos + 1) % HA;
            pend_pat = int'(pat);
         end
         k_cyc++;
      end
   end

   // ---------------- per-cycle compare ----------------
   int cyc = 0;
   int last_fs = -1;
   always @(negedge clk) begin
      if (model_ok) begin
         checks++;
         if ({o_hs, o_vs, o_de, o_fs, o_r, o_g, o_b} !==
             {exp_hs, exp_vs, exp_de, exp_fs, exp_rgb}) begin
            errors++;
            if (errors < 20)
               $display("FAIL cycle x=%0d y=%0d got hs%b vs%b de%b fs%b rgb=%h want hs%b vs%b de%b fs%b rgb=%h",
                        exp_x, exp_y, o_hs, o_vs, o_de, o_fs, {o_r, o_g, o_b},
                        exp_hs, exp_vs, exp_de, exp_fs, exp_rgb);
         end
         if (!exp_valid) begin
            last_fs = -1;
         end else if (o_fs === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (cyc - last_fs != 5546) begin
                  errors++;
                  $display("FAIL fs_period got %0d want 5546", cyc - last_fs);
               end
            end
            last_fs = cyc;
         end
      end
      cyc++;
   end

   // ---------------- directed helpers ----------------
   task automatic wait_pos(input int x, input int y);
      int c = 0;
      @(negedge clk);
      while (!(exp_valid && exp_x == x && exp_y == y) && c < LIM) begin
         @(negedge clk);
         c++;
      end
      if (c >= LIM) begin
         checks++;
         errors++;
         $display("FAIL wait_pos timeout at (%0d,%0d)", x, y);
      end
   endtask

   task automatic chk_rgb(input string nm, input int x, input int y, input logic [11:0] lit);
      wait_pos(x, y);
      checks++;
      if ({o_r, o_g, o_b} !== lit) begin
         errors++;
         $display("FAIL %s (%0d,%0d) got %h want %h", nm, x, y, {o_r, o_g, o_b}, lit);
      end
   endtask

   task automatic chk_ctl(input string nm, input int x, input int y, input logic [2:0] lit);
      wait_pos(x, y);
      checks++;
      if ({o_hs, o_vs, o_de} !== lit) begin
         errors++;
         $display("FAIL %s (%0d,%0d) got hs/vs/de=%b want %b", nm, x, y, {o_hs, o_vs, o_de}, lit);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      checks++;
      if ({o_hs, o_vs, o_de, o_fs, o_r, o_g, o_b} !== {4'b1100, 12'h000}) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, {o_hs, o_vs, o_de, o_fs, o_r, o_g, o_b}, {4'b1100, 12'h000});
      end
   endtask

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("reset_state");
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o_fs !== 1'b1) begin
         errors++;
         $display("FAIL first_fs got %b want 1", o_fs);
      end

      // frame 0: solid colour 101_110_01
      chk_rgb("solid", 5, 5, 12'hBD5);
      chk_ctl("de_last", 99, 5, 3'b111);
      chk_ctl("hs_before", 103, 5, 3'b110);
      chk_ctl("hs_start", 104, 5, 3'b010);
      chk_rgb("blank_rgb", 104, 5, 12'h000);
      chk_ctl("hs_end", 112, 5, 3'b110);
      wait_pos(0, 10);
      pat = 4'd2;
      chk_ctl("vs_before", 0, 41, 3'b110);
      chk_ctl("vs_start", 0, 42, 3'b100);
      chk_ctl("vs_end", 0, 44, 3'b110);

      // frame 1: colour bars, 12 px wide, remainder in bar 7
      chk_rgb("bar0", 0, 5, 12'h000);
      chk_rgb("bar1", 12, 5, 12'h00F);
      chk_rgb("bar5", 60, 5, 12'hF0F);
      chk_rgb("bar6", 83, 5, 12'hFF0);
      chk_rgb("bar_rem", 96, 5, 12'hFFF);
      chk_rgb("bar_last", 99, 5, 12'hFFF);
      wait_pos(0, 10);
      pat = 4'd3;

      // frame 2: checkerboard; the mid-frame change to 4 must be ignored
      chk_rgb("chk00", 0, 0, 12'hFFF);
      chk_rgb("chk32", 32, 0, 12'h000);
      wait_pos(0, 20);
      pat = 4'd4;
      chk_rgb("chk_hold_w", 10, 25, 12'hFFF);
      chk_rgb("chk_hold_b", 40, 25, 12'h000);
      chk_rgb("chk_y33", 0, 33, 12'h000);
      chk_rgb("chk_xy33", 32, 33, 12'hFFF);

      // frame 3: ramp, step 4 px, wraps every 64 px
      chk_rgb("ramp4", 4, 0, 12'h111);
      chk_rgb("ramp63", 63, 0, 12'hFFF);
      chk_rgb("ramp64", 64, 0, 12'h000);
      chk_rgb("ramp99", 99, 0, 12'h888);
      wait_pos(0, 10);
      pat = 4'd5;

      // frame 4: border
      chk_rgb("brd_top", 50, 0, 12'hFFF);
      chk_rgb("brd_left", 0, 10, 12'hFFF);
      chk_rgb("brd_in", 50, 10, 12'h000);
      chk_rgb("brd_right", 99, 10, 12'hFFF);
      pat = 4'd6;
      chk_rgb("brd_bot", 50, 39, 12'hFFF);

      // frames 5..7: pattern 6
`ifdef VGA_PATTERN_GEN_ANIM_EN
      chk_rgb("anim0_l", 0, 5, 12'hFFF);
      chk_rgb("anim0_r", 15, 5, 12'hFFF);
      chk_rgb("anim0_o", 16, 5, 12'h000);
      chk_rgb("anim1_l", 0, 5, 12'h000);
      chk_rgb("anim1_r", 16, 5, 12'hFFF);
      chk_rgb("anim1_o", 17, 5, 12'h000);
      chk_rgb("anim2_l", 1, 5, 12'h000);
      chk_rgb("anim2_s", 2, 5, 12'hFFF);
      chk_rgb("anim2_r", 17, 5, 12'hFFF);
      chk_rgb("anim2_o", 18, 5, 12'h000);
`else
      chk_rgb("p6_black0", 0, 5, 12'h000);
      chk_rgb("p6_black1", 16, 5, 12'h000);
      chk_rgb("p6_black2", 2, 5, 12'h000);
`endif

      // random phase: pattern and colour changes at arbitrary times
      for (int i = 0; i < (FRAME * 3) / 2; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 199) == 0) pat = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) rgb = 8'($urandom);
      end

      // mid-frame reset
      wait_pos(30, 20);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midframe_reset");
      pat = 4'd1;
      rgb = 8'b111_000_11;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_fs, o_r, o_g, o_b} !== {1'b1, 12'hF0F}) begin
         errors++;
         $display("FAIL restart got fs=%b rgb=%h want fs=1 rgb=f0f", o_fs, {o_r, o_g, o_b});
      end
      chk_rgb("restart_pix", 5, 5, 12'hF0F);

      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) pat = 4'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) rgb = 8'($urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
